// File: rtl/pr_reclaim_buffer.sv
// pr_reclaim_buffer
// Collects the old destination physical registers released at ROB retirement
// (up to RETIRE_W per cycle) in a small FIFO. It then hands them to the free
// list one at a time. Each hand-off takes an ISSUE cycle and a CONFIRM cycle.
// The free list's registered was_enqueued, sampled in CONFIRM, decides whether
// the head is popped or reissued.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous, active-high
//   retire_valid  per-slot valid (slot 0 is the oldest)
//   retire_pr     old destination PR per slot
//   retire_ready  at least RETIRE_W free FIFO slots (from registered count)
//   enqueue_en    push request to the free list (high only in ISSUE)
//   enqueue_pr    PR at the FIFO head
//   was_enqueued  free-list ack for the previous cycle's request
//   count         occupied FIFO entries
//   overflow_err  sticky: a valid slot was presented while !retire_ready
//   retry_err     sticky: MAX_RETRY consecutive refusals
module pr_reclaim_buffer #(
    parameter int PR_W      = 7,
    parameter int DEPTH     = 8,
    parameter int RETIRE_W  = 2,
    parameter int MAX_RETRY = 15
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [RETIRE_W-1:0]                 retire_valid,
    input  logic [RETIRE_W-1:0][PR_W-1:0]       retire_pr,
    output logic                                retire_ready,
    output logic                                enqueue_en,
    output logic [PR_W-1:0]                     enqueue_pr,
    input  logic                                was_enqueued,
    output logic [$clog2(DEPTH):0]              count,
    output logic                                overflow_err,
    output logic                                retry_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int RC_W  = $clog2(MAX_RETRY + 1);
    localparam logic [PR_W-1:0] ZERO_REG = '0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CONFIRM = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PR_W-1:0]   fifo_q [DEPTH];
    logic [PR_W-1:0]   fifo_d [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [RC_W-1:0]   retry_cnt_q, retry_cnt_d;
    logic              overflow_err_q, overflow_err_d;
    logic              retry_err_q, retry_err_d;

    logic [CNT_W-1:0]  n_push;
    logic [PTR_W-1:0]  wr_ptr;
    logic              pop;

    // retire_ready uses the pre-edge count, so a slot freed by a pop this
    // edge is not offered to retirement until the next cycle.
    assign retire_ready = (CNT_W'(DEPTH) - count_q) >= CNT_W'(RETIRE_W);
    assign pop          = (state_q == CONFIRM) && was_enqueued;

    assign enqueue_en   = (state_q == ISSUE);
    assign enqueue_pr   = fifo_q[head_q];
    assign count        = count_q;
    assign overflow_err = overflow_err_q;
    assign retry_err    = retry_err_q;

    // Push path: valid non-zero slots are packed at the tail in slot order.
    always_comb begin
        fifo_d         = fifo_q;
        wr_ptr         = tail_q;
        n_push         = '0;
        overflow_err_d = overflow_err_q;
        for (int i = 0; i < RETIRE_W; i++) begin
            if (retire_valid[i]) begin
                if (!retire_ready) begin
                    overflow_err_d = 1'b1;
                end else if (retire_pr[i] != ZERO_REG) begin
                    fifo_d[wr_ptr] = retire_pr[i];
                    wr_ptr         = wr_ptr + PTR_W'(1);
                    n_push         = n_push + CNT_W'(1);
                end
            end
        end
        tail_d  = wr_ptr;
        head_d  = pop ? head_q + PTR_W'(1) : head_q;
        count_d = count_q + n_push - CNT_W'(pop);
    end

    always_comb begin
        state_d     = state_q;
        retry_cnt_d = retry_cnt_q;
        retry_err_d = retry_err_q;
        unique case (state_q)
            IDLE: begin
                if (count_q != '0) state_d = ISSUE;
            end
            ISSUE: begin
                state_d = CONFIRM;
            end
            CONFIRM: begin
                if (was_enqueued) begin
                    retry_cnt_d = '0;
                    // Occupancy after this edge decides whether another issue follows.
                    state_d = ((count_q - CNT_W'(1) + n_push) != '0) ? ISSUE : IDLE;
                end else begin
                    if (retry_cnt_q != RC_W'(MAX_RETRY)) retry_cnt_d = retry_cnt_q + RC_W'(1);
                    if (retry_cnt_d == RC_W'(MAX_RETRY)) retry_err_d = 1'b1;
                    state_d = ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            retry_cnt_q    <= '0;
            overflow_err_q <= 1'b0;
            retry_err_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            state_q        <= state_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            retry_cnt_q    <= retry_cnt_d;
            overflow_err_q <= overflow_err_d;
            retry_err_q    <= retry_err_d;
            fifo_q         <= fifo_d;
        end
    end

endmodule

// File: tb/tb_pr_reclaim_buffer.sv
// Directed bench for pr_reclaim_buffer (PR_W=7, DEPTH=8, RETIRE_W=2, MAX_RETRY=15).
module tb_pr_reclaim_buffer;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       retire_valid;
    logic [1:0][6:0]  retire_pr;
    logic             retire_ready;
    logic             enqueue_en;
    logic [6:0]       enqueue_pr;
    logic             was_enqueued;
    logic [3:0]       count;
    logic             overflow_err;
    logic             retry_err;

    int tests = 0;
    int fails = 0;

    pr_reclaim_buffer #(.PR_W(7), .DEPTH(8), .RETIRE_W(2), .MAX_RETRY(15)) dut (
        .clk(clk), .reset(reset), .retire_valid(retire_valid), .retire_pr(retire_pr),
        .retire_ready(retire_ready), .enqueue_en(enqueue_en), .enqueue_pr(enqueue_pr),
        .was_enqueued(was_enqueued), .count(count), .overflow_err(overflow_err),
        .retry_err(retry_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1; retire_valid = '0; retire_pr = '0; was_enqueued = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        tests++;
        if (count !== 4'd0 || enqueue_en !== 1'b0 || enqueue_pr !== 7'd0 ||
            overflow_err !== 1'b0 || retry_err !== 1'b0 || retire_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset: cnt=%0d en=%b pr=%0d ovf=%b rerr=%b rdy=%b, need 0 0 0 0 0 1",
                     count, enqueue_en, enqueue_pr, overflow_err, retry_err, retire_ready);
        end
    endtask

    task automatic test_single();
        was_enqueued = 1'b1;
        retire_valid = 2'b01; retire_pr[0] = 7'd5; retire_pr[1] = 7'd0;
        tick();
        retire_valid = '0;
        tests++;
        if (count !== 4'd1 || enqueue_en !== 1'b0) begin
            fails++; $display("FAIL single_push: cnt=%0d en=%b, need 1 0", count, enqueue_en);
        end
        tick();
        tests++;
        if (enqueue_en !== 1'b1 || enqueue_pr !== 7'd5) begin
            fails++; $display("FAIL single_issue: en=%b pr=%0d, need 1 5", enqueue_en, enqueue_pr);
        end
        tick();
        tests++;
        if (enqueue_en !== 1'b0 || count !== 4'd1) begin
            fails++; $display("FAIL single_confirm: en=%b cnt=%0d, need 0 1", enqueue_en, count);
        end
        tick(); tick();
        tests++;
        if (count !== 4'd0 || enqueue_en !== 1'b0) begin
            fails++; $display("FAIL single_idle: cnt=%0d en=%b, need 0 0", count, enqueue_en);
        end
    endtask

    task automatic test_two_slot();
        was_enqueued = 1'b1;
        retire_valid = 2'b11; retire_pr[0] = 7'd7; retire_pr[1] = 7'd9;
        tick();
        retire_valid = '0;
        tests++;
        if (count !== 4'd2) begin
            fails++; $display("FAIL two_push: cnt=%0d, need 2", count);
        end
        tick();
        tests++;
        if (enqueue_en !== 1'b1 || enqueue_pr !== 7'd7) begin
            fails++; $display("FAIL two_first: en=%b pr=%0d, need 1 7", enqueue_en, enqueue_pr);
        end
        tick();
        tick();
        tests++;
        if (enqueue_en !== 1'b1 || enqueue_pr !== 7'd9 || count !== 4'd1) begin
            fails++; $display("FAIL two_second: en=%b pr=%0d cnt=%0d, need 1 9 1",
                              enqueue_en, enqueue_pr, count);
        end
        tick(); tick();
        tests++;
        if (count !== 4'd0 || enqueue_en !== 1'b0) begin
            fails++; $display("FAIL two_drain: cnt=%0d en=%b, need 0 0", count, enqueue_en);
        end
    endtask

    task automatic test_zero_drop();
        was_enqueued = 1'b1;
        retire_valid = 2'b11; retire_pr[0] = 7'd0; retire_pr[1] = 7'd4;
        tick();
        retire_valid = '0;
        tests++;
        if (count !== 4'd1) begin
            fails++; $display("FAIL zero_count: cnt=%0d, need 1", count);
        end
        tick();
        tests++;
        if (enqueue_en !== 1'b1 || enqueue_pr !== 7'd4) begin
            fails++; $display("FAIL zero_issue: en=%b pr=%0d, need 1 4", enqueue_en, enqueue_pr);
        end
        tick(); tick(); tick();
        tests++;
        if (count !== 4'd0 || enqueue_en !== 1'b0) begin
            fails++; $display("FAIL zero_drain: cnt=%0d en=%b, need 0 0", count, enqueue_en);
        end
    endtask

    task automatic test_overflow();
        was_enqueued = 1'b0;
        retire_valid = 2'b11; retire_pr[0] = 7'd10; retire_pr[1] = 7'd11; tick();
        retire_pr[0] = 7'd12; retire_pr[1] = 7'd13; tick();
        retire_pr[0] = 7'd14; retire_pr[1] = 7'd15; tick();
        retire_valid = '0;
        tests++;
        if (count !== 4'd6 || retire_ready !== 1'b1) begin
            fails++; $display("FAIL ovf_six: cnt=%0d rdy=%b, need 6 1", count, retire_ready);
        end
        retire_valid = 2'b01; retire_pr[0] = 7'd16; retire_pr[1] = 7'd0; tick();
        retire_valid = '0;
        tests++;
        if (count !== 4'd7 || retire_ready !== 1'b0 || overflow_err !== 1'b0) begin
            fails++; $display("FAIL ovf_seven: cnt=%0d rdy=%b ovf=%b, need 7 0 0",
                              count, retire_ready, overflow_err);
        end
        retire_valid = 2'b01; retire_pr[0] = 7'd3; tick();
        retire_valid = '0;
        tests++;
        if (count !== 4'd7 || overflow_err !== 1'b1) begin
            fails++; $display("FAIL ovf_drop: cnt=%0d ovf=%b, need 7 1", count, overflow_err);
        end
    endtask

    task automatic test_retry();
        int issues = 0;
        was_enqueued = 1'b0;
        retire_valid = 2'b01; retire_pr[0] = 7'd6; retire_pr[1] = 7'd0;
        tick();
        retire_valid = '0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (enqueue_en) begin
                issues++;
                tests++;
                if (enqueue_pr !== 7'd6) begin
                    fails++; $display("FAIL retry_pr: pr=%0d, need 6", enqueue_pr);
                end
                was_enqueued = (issues >= 3);
            end
            if (count == 4'd0) break;
        end
        tick(); tick();
        tests++;
        if (issues != 3 || count !== 4'd0 || retry_err !== 1'b0) begin
            fails++; $display("FAIL retry_three: issues=%0d cnt=%0d rerr=%b, need 3 0 0",
                              issues, count, retry_err);
        end
        was_enqueued = 1'b0;
    endtask

    task automatic test_retry_err();
        int  issues = 0;
        bit  seen   = 0;
        was_enqueued = 1'b0;
        retire_valid = 2'b01; retire_pr[0] = 7'd8; retire_pr[1] = 7'd0;
        tick();
        retire_valid = '0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (retry_err) begin seen = 1; break; end
            if (enqueue_en) issues++;
        end
        tests++;
        if (!seen || issues != 15 || count !== 4'd1) begin
            fails++; $display("FAIL retry_err: seen=%0d refusals=%0d cnt=%0d, need 1 15 1",
                              seen, issues, count);
        end
    endtask

    task automatic test_reset_mid();
        was_enqueued = 1'b0;
        retire_valid = 2'b11; retire_pr[0] = 7'd20; retire_pr[1] = 7'd21; tick();
        retire_valid = 2'b01; retire_pr[0] = 7'd22; retire_pr[1] = 7'd0;  tick();
        retire_valid = '0;
        tests++;
        if (count !== 4'd3 || enqueue_en !== 1'b1 || enqueue_pr !== 7'd20) begin
            fails++; $display("FAIL mid_setup: cnt=%0d en=%b pr=%0d, need 3 1 20",
                              count, enqueue_en, enqueue_pr);
        end
        tick();
        reset = 1'b1;
        #1;
        tests++;
        if (count !== 4'd0 || enqueue_en !== 1'b0 || enqueue_pr !== 7'd0 ||
            overflow_err !== 1'b0 || retry_err !== 1'b0) begin
            fails++; $display("FAIL mid_reset: cnt=%0d en=%b pr=%0d ovf=%b rerr=%b, need all 0",
                              count, enqueue_en, enqueue_pr, overflow_err, retry_err);
        end
        was_enqueued = 1'b1;
        tick();
        reset = 1'b0;
        tick(); tick();
        tests++;
        if (count !== 4'd0 || enqueue_en !== 1'b0) begin
            fails++; $display("FAIL mid_after: cnt=%0d en=%b, need 0 0", count, enqueue_en);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_two_slot();
        test_zero_drop();
        test_overflow();
        apply_reset();
        test_retry();
        test_retry_err();
        apply_reset();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
